dmem_arbiter: RTL and testbench

Two-port access controller for the 8 K-word data memory. It shares one synchronous-read memory port between the core load/store unit and the UART debug host (narvie register and memory poke). It also:
- generates byte enables and store lane alignment,
- extracts and sign/zero-extends load data,
- flags misaligned and out-of-range accesses.

Sits between the core/debug interfaces and the memory array.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states and requester IDs.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Core-path lane logic: store byte enables/data alignment, misalignment detect,
// and load lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        misalign_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    // Replicating narrow data across the word lets be alone pick the lane.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = st_wdata_i;
        misalign_o = 1'b0;
        case (st_size_i)
            SIZE_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SIZE_H: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
                misalign_o = st_off_i[0];
            end
            SIZE_W: begin
                st_be_o    = 4'b1111;
                misalign_o = |st_off_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_size_i)
            SIZE_B: ld_data_o = {{24{~ld_unsigned_i & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_H: ld_data_o = {{16{~ld_unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data-memory port between the core LSU and the debug host.
// Define DMEM_ARB_DBG_PRIORITY_EN for fixed debug-wins-ties arbitration instead of round-robin.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_AW = 13,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [XLEN-1:0]   core_addr,
    input  logic [XLEN-1:0]   core_wdata,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [XLEN-1:0]   core_rdata,
    output logic              core_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [XLEN-1:0]   dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_e            state_q, state_d;
    req_id_e           owner_q;
    logic              we_q, fault_q, ld_uns_q;
    logic [1:0]        ld_size_q, ld_off_q;
    logic              mem_en_q, mem_we_q;
    logic [3:0]        mem_be_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;

    logic              can_gnt, gnt_any, fault_d;
    logic              core_oor, dbg_oor, core_misalign;
    logic [3:0]        core_be;
    logic [XLEN-1:0]   core_wd_al, ld_data;
    logic [XLEN-1:0]   sel_addr;
    logic [1:0]        dbg_addr_unused;

    assign dbg_addr_unused = dbg_addr[1:0];

    dmem_lane_align u_lane (
        .st_size_i     (core_size),
        .st_off_i      (core_addr[1:0]),
        .st_wdata_i    (core_wdata),
        .st_be_o       (core_be),
        .st_wdata_o    (core_wd_al),
        .misalign_o    (core_misalign),
        .ld_size_i     (ld_size_q),
        .ld_off_i      (ld_off_q),
        .ld_unsigned_i (ld_uns_q),
        .ld_rdata_i    (mem_rdata),
        .ld_data_o     (ld_data)
    );

    assign core_oor = |core_addr[XLEN-1:MEM_AW+2];
    assign dbg_oor  = |dbg_addr[XLEN-1:MEM_AW+2];
    assign can_gnt  = (state_q != ST_ISSUE);

`ifdef DMEM_ARB_DBG_PRIORITY_EN
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (can_gnt) begin
            dbg_gnt  = dbg_req;
            core_gnt = core_req & ~dbg_req;
        end
    end
`else
    req_id_e last_gnt_q;

    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (can_gnt) begin
            if (core_req && dbg_req) begin
                core_gnt = (last_gnt_q == REQ_DBG);
                dbg_gnt  = (last_gnt_q == REQ_CORE);
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt_q <= REQ_DBG;
        else if (core_gnt)
            last_gnt_q <= REQ_CORE;
        else if (dbg_gnt)
            last_gnt_q <= REQ_DBG;
    end
`endif

    assign gnt_any  = core_gnt | dbg_gnt;
    assign fault_d  = dbg_gnt ? dbg_oor : (core_misalign | core_oor);
    assign sel_addr = dbg_gnt ? dbg_addr : core_addr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gnt_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = gnt_any ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory strobes live for exactly the ISSUE cycle; a faulted grant never strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_CORE;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            ld_size_q   <= SIZE_W;
            ld_off_q    <= 2'b00;
            ld_uns_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= gnt_any & ~fault_d;
            mem_we_q    <= gnt_any & ~fault_d & (dbg_gnt ? dbg_we : core_we);
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (gnt_any) begin
                owner_q   <= dbg_gnt ? REQ_DBG : REQ_CORE;
                we_q      <= dbg_gnt ? dbg_we : core_we;
                fault_q   <= fault_d;
                ld_size_q <= dbg_gnt ? SIZE_W : core_size;
                ld_off_q  <= dbg_gnt ? 2'b00 : core_addr[1:0];
                ld_uns_q  <= core_unsigned;
                if (!fault_d) begin
                    mem_be_q    <= dbg_gnt ? 4'b1111 : core_be;
                    mem_addr_q  <= sel_addr[MEM_AW+1:2];
                    mem_wdata_q <= dbg_gnt ? dbg_wdata : core_wd_al;
                end
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Response data is gated to zero outside rvalid, on faults, and for stores.
    assign core_rvalid = (state_q == ST_RESP) && (owner_q == REQ_CORE);
    assign dbg_rvalid  = (state_q == ST_RESP) && (owner_q == REQ_DBG);
    assign core_err    = core_rvalid & fault_q;
    assign dbg_err     = dbg_rvalid & fault_q;
    assign core_rdata  = (core_rvalid && !we_q && !fault_q) ? ld_data : '0;
    assign dbg_rdata   = (dbg_rvalid && !we_q && !fault_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: memory model on the mem_* port and a response scoreboard.
module tb_dmem_arbiter;

    logic        clk, rst_n;
    logic        core_req, core_we, core_unsigned;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_size;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:8191];
    int          n_chk = 0;
    int          n_fail = 0;

    dmem_arbiter #(.MEM_AW(13), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_size(core_size), .core_unsigned(core_unsigned),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a negedge; drives one access and checks grant, mem_* and response.
    task automatic access(input bit dbg, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                          input logic [3:0] be, input logic [31:0] exp_wd,
                          input logic [31:0] rd, input bit err, input string tag);
        int   n;
        exp_t e;
        n = 0;
        exp_q.push_back('{rd: rd, err: err});
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
            core_size = size; core_unsigned = uns;
        end
        #1;
        while (!(dbg ? dbg_gnt : core_gnt) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_gnt"}, {31'b0, (dbg ? dbg_gnt : core_gnt)}, 32'd1);
        @(negedge clk);
        core_req = 1'b0;
        dbg_req  = 1'b0;
        chk({tag, "_mem_en"}, {31'b0, mem_en}, {31'b0, ~err});
        if (!err) begin
            chk({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, we});
            chk({tag, "_mem_be"}, {28'b0, mem_be}, {28'b0, be});
            chk({tag, "_mem_addr"}, {19'b0, mem_addr}, {19'b0, addr[14:2]});
            if (we) chk({tag, "_mem_wdata"}, mem_wdata & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}},
                        exp_wd & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});
        end
        @(negedge clk);
        chk({tag, "_rvalid"}, {31'b0, (dbg ? dbg_rvalid : core_rvalid)}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, dbg ? dbg_rdata : core_rdata, e.rd);
            chk({tag, "_err"}, {31'b0, (dbg ? dbg_err : core_err)}, {31'b0, e.err});
        end
    endtask

    initial begin
        logic [5:0] exp_c, exp_d;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_size = 2'b10; core_unsigned = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_core_rvalid", {31'b0, core_rvalid}, 32'd0);
        chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);

        // Both requesters held from reset release: one grant every other cycle.
`ifdef DMEM_ARB_DBG_PRIORITY_EN
        exp_c = 6'b000000; exp_d = 6'b010101;
`else
        exp_c = 6'b010001; exp_d = 6'b000100;
`endif
        rst_n = 1'b1;
        core_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("tie_core_gnt_c%0d", i), {31'b0, core_gnt}, {31'b0, exp_c[i]});
            chk($sformatf("tie_dbg_gnt_c%0d", i), {31'b0, dbg_gnt}, {31'b0, exp_d[i]});
            if (i == 5) begin core_req = 1'b0; dbg_req = 1'b0; end
            @(negedge clk);
        end
        @(negedge clk);

        access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 0, "sw10");
        access(0, 0, 32'h10, 32'h0, 2'b10, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 0, "lw10");
        access(0, 1, 32'h13, 32'h000000A5, 2'b00, 0, 4'b1000, 32'hA5000000, 32'h0, 0, "sb13");
        access(0, 0, 32'h13, 32'h0, 2'b00, 0, 4'b1000, 32'h0, 32'hFFFFFFA5, 0, "lb13");
        access(0, 0, 32'h13, 32'h0, 2'b00, 1, 4'b1000, 32'h0, 32'h000000A5, 0, "lbu13");
        access(0, 0, 32'h12, 32'h0, 2'b01, 0, 4'b1100, 32'h0, 32'hFFFFA5AD, 0, "lh12");
        access(0, 0, 32'h12, 32'h0, 2'b01, 1, 4'b1100, 32'h0, 32'h0000A5AD, 0, "lhu12");
        access(0, 0, 32'h10, 32'h0, 2'b00, 0, 4'b0001, 32'h0, 32'hFFFFFFEF, 0, "lb10");
        access(0, 1, 32'h16, 32'h0000BEEF, 2'b01, 0, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, "sh16");

        access(0, 0, 32'h6, 32'h0, 2'b10, 0, 4'b0000, 32'h0, 32'h0, 1, "lw6_mis");
        access(0, 0, 32'h3, 32'h0, 2'b01, 0, 4'b0000, 32'h0, 32'h0, 1, "lh3_mis");
        access(0, 1, 32'h8, 32'h5, 2'b11, 0, 4'b0000, 32'h0, 32'h0, 1, "size11");
        access(0, 0, 32'h8000, 32'h0, 2'b10, 0, 4'b0000, 32'h0, 32'h0, 1, "core_oor");

        access(1, 0, 32'h8000, 32'h0, 2'b10, 0, 4'b0000, 32'h0, 32'h0, 1, "dbg_oor");
        access(1, 1, 32'h20, 32'h12345678, 2'b10, 0, 4'b1111, 32'h12345678, 32'h0, 0, "dbg_w20");
        access(0, 0, 32'h20, 32'h0, 2'b10, 0, 4'b1111, 32'h0, 32'h12345678, 0, "core_lw20");
        access(1, 0, 32'h23, 32'h0, 2'b10, 0, 4'b1111, 32'h0, 32'h12345678, 0, "dbg_r23");

        // Reset lands in the ISSUE cycle of a store: the store must vanish.
        access(0, 1, 32'h40, 32'h11111111, 2'b10, 0, 4'b1111, 32'h11111111, 32'h0, 0, "sw40a");
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h22222222; core_size = 2'b10;
        #1;
        chk("rst_sw_gnt", {31'b0, core_gnt}, 32'd1);
        @(negedge clk);
        core_req = 1'b0;
        chk("rst_sw_issue_en", {31'b0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_sw_en_cleared", {31'b0, mem_en}, 32'd0);
        chk("rst_sw_we_cleared", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst_sw_no_rvalid", {31'b0, core_rvalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sw_no_rvalid2", {31'b0, core_rvalid}, 32'd0);
        access(0, 0, 32'h40, 32'h0, 2'b10, 0, 4'b1111, 32'h0, 32'h11111111, 0, "lw40_after_rst");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
